// File: rtl/isa_push_if.sv
// -----------------------------------------------------------------------------
// isa_push_if
// Bus bundle between the push execution unit and its environment
// (instruction sequencer, register file and RAM port).
//   enabled   sequencer -> unit  : execute enable for one push
//   r0        sequencer -> unit  : source register index
//   ram_txe   RAM -> unit        : handshake ack (0 = start seen, 1 = done)
//   reg_out   regfile -> unit    : read data for reg_id while reg_re=1
//   ram_txs   unit -> RAM        : transaction strobe, idle high
//   ram_we    unit -> RAM        : write enable
//   ram_addr  unit -> RAM        : word address (latched SP)
//   ram_in    unit -> RAM        : write data (latched register half)
//   reg_id    unit -> regfile    : register index
//   reg_wd    unit -> regfile    : write data
//   reg_re    unit -> regfile    : read enable
//   reg_we    unit -> regfile    : write enable
//   finished  unit -> sequencer  : push complete, held until enabled falls
// -----------------------------------------------------------------------------
interface isa_push_if;
  logic        enabled;
  logic [3:0]  r0;
  logic        ram_txe;
  logic [63:0] reg_out;
  logic        ram_txs;
  logic        ram_we;
  logic [63:0] ram_addr;
  logic [31:0] ram_in;
  logic [3:0]  reg_id;
  logic [63:0] reg_wd;
  logic        reg_re;
  logic        reg_we;
  logic        finished;

  // Environment side: sequencer, register file and RAM.
  modport master (
    output enabled, r0, ram_txe, reg_out,
    input  ram_txs, ram_we, ram_addr, ram_in, reg_id, reg_wd, reg_re, reg_we, finished
  );

  // Push unit side.
  modport slave (
    input  enabled, r0, ram_txe, reg_out,
    output ram_txs, ram_we, ram_addr, ram_in, reg_id, reg_wd, reg_re, reg_we, finished
  );
endinterface

// File: rtl/isa_push.sv
// -----------------------------------------------------------------------------
// isa_push
// Executes PUSH r0: MEM[SP] = half(R[r0]); SP = SP + 1, with SP in R15.
// The stack grows upward. PART_ID picks the stored 32-bit half
// (0 = bits [31:0], 1 = bits [63:32]).
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  isa_push_if.slave (sequencer, register file and RAM signals)
// All outputs are registered; ram_addr/ram_in come straight from the
// SP and data latches so they stay stable across the RAM handshake.
// -----------------------------------------------------------------------------
module isa_push #(
  parameter int PART_ID = 0
) (
  input  logic      clk,
  input  logic      rst,
  isa_push_if.slave bus
);

  typedef enum logic [2:0] {
    S_READ_SP   = 3'd0,
    S_READ_SRC  = 3'd1,
    S_LATCH     = 3'd2,
    S_RAM_BEGIN = 3'd3,
    S_RAM_END   = 3'd4,
    S_WRITE_SP  = 3'd5,
    S_CLEAN     = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  state_e      state_q,    state_d;
  logic [3:0]  reg_id_q,   reg_id_d;
  logic [63:0] reg_wd_q,   reg_wd_d;
  logic        reg_re_q,   reg_re_d;
  logic        reg_we_q,   reg_we_d;
  logic        ram_txs_q,  ram_txs_d;
  logic        ram_we_q,   ram_we_d;
  logic        finished_q, finished_d;
  logic [63:0] sp_q,       sp_d;
  logic [31:0] data_q,     data_d;
  logic [31:0] src_half;

  assign src_half = (PART_ID != 0) ? bus.reg_out[63:32] : bus.reg_out[31:0];

  // State and output registers; reset drops the RAM strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_READ_SP;
      reg_id_q   <= 4'd0;
      reg_wd_q   <= 64'd0;
      reg_re_q   <= 1'b0;
      reg_we_q   <= 1'b0;
      ram_txs_q  <= 1'b1;
      ram_we_q   <= 1'b0;
      finished_q <= 1'b0;
      sp_q       <= 64'd0;
      data_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      reg_id_q   <= reg_id_d;
      reg_wd_q   <= reg_wd_d;
      reg_re_q   <= reg_re_d;
      reg_we_q   <= reg_we_d;
      ram_txs_q  <= ram_txs_d;
      ram_we_q   <= ram_we_d;
      finished_q <= finished_d;
      sp_q       <= sp_d;
      data_q     <= data_d;
    end
  end

  // Next-state logic; dropping enabled abandons the push.
  always_comb begin
    state_d = state_q;
    if (!bus.enabled) begin
      state_d = S_READ_SP;
    end else begin
      case (state_q)
        S_READ_SP:   state_d = S_READ_SRC;
        S_READ_SRC:  state_d = S_LATCH;
        S_LATCH:     state_d = S_RAM_BEGIN;
        S_RAM_BEGIN: begin
          if (!bus.ram_txe) begin
            state_d = S_RAM_END;
          end else begin
            state_d = S_RAM_BEGIN;
          end
        end
        S_RAM_END: begin
          if (bus.ram_txe) begin
            state_d = S_WRITE_SP;
          end else begin
            state_d = S_RAM_END;
          end
        end
        S_WRITE_SP:  state_d = S_CLEAN;
        S_CLEAN:     state_d = S_DONE;
        S_DONE:      state_d = S_DONE;
        default:     state_d = S_READ_SP;
      endcase
    end
  end

  // Next values of the registered outputs and latches.
  always_comb begin
    reg_id_d   = reg_id_q;
    reg_wd_d   = reg_wd_q;
    reg_re_d   = reg_re_q;
    reg_we_d   = reg_we_q;
    ram_txs_d  = ram_txs_q;
    ram_we_d   = ram_we_q;
    finished_d = finished_q;
    sp_d       = sp_q;
    data_d     = data_q;
    if (!bus.enabled) begin
      // Idle the buses; reg_id/reg_wd and both latches keep their values.
      finished_d = 1'b0;
      reg_re_d   = 1'b0;
      reg_we_d   = 1'b0;
      ram_we_d   = 1'b0;
      ram_txs_d  = 1'b1;
    end else begin
      case (state_q)
        S_READ_SP: begin
          reg_id_d = 4'd15;
          reg_re_d = 1'b1;
        end
        S_READ_SRC: begin
          sp_d     = bus.reg_out;
          reg_id_d = bus.r0;
        end
        S_LATCH: begin
          // When r0=15 this re-reads SP, i.e. the pre-increment value.
          data_d    = src_half;
          reg_re_d  = 1'b0;
          ram_txs_d = 1'b0;
        end
        S_RAM_BEGIN: begin
          if (!bus.ram_txe) begin
            ram_txs_d = 1'b1;
            ram_we_d  = 1'b1;
          end else begin
            ram_txs_d = 1'b0;
          end
        end
        S_RAM_END: begin
          if (bus.ram_txe) begin
            ram_we_d = 1'b0;
          end else begin
            ram_txs_d = 1'b1;
            ram_we_d  = 1'b1;
          end
        end
        S_WRITE_SP: begin
          reg_id_d = 4'd15;
          reg_wd_d = sp_q + 64'd1;
          reg_we_d = 1'b1;
        end
        S_CLEAN: begin
          reg_we_d   = 1'b0;
          finished_d = 1'b1;
        end
        S_DONE: begin
          finished_d = finished_q;
        end
        default: begin
          reg_re_d   = 1'b0;
          reg_we_d   = 1'b0;
          ram_we_d   = 1'b0;
          ram_txs_d  = 1'b1;
          finished_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_txs  = ram_txs_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = sp_q;
  assign bus.ram_in   = data_q;
  assign bus.reg_id   = reg_id_q;
  assign bus.reg_wd   = reg_wd_q;
  assign bus.reg_re   = reg_re_q;
  assign bus.reg_we   = reg_we_q;
  assign bus.finished = finished_q;

endmodule
